// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU operation encodings, ALUOp class constants and issue-controller state type.
package alu_issue_ctrl_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0011,
        ALU_XOR     = 4'b0100,
        ALU_SRL     = 4'b0101,
        ALU_SLL     = 4'b0110,
        ALU_EQUAL   = 4'b1000,
        ALU_LUI     = 4'b1001,
        ALU_SLT     = 4'b1110,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_LUI    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and result signals between the issue controller (slave) and its environment (master).
interface alu_issue_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic                     IsImm;
    logic [DATA_WIDTH-1:0]    OpA;
    logic [DATA_WIDTH-1:0]    OpB;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    ALUResult;
    logic                     res_valid;
    logic                     res_ready;
    logic [DATA_WIDTH-1:0]    Result;
    logic                     res_err;

    modport slave (
        input  in_valid, ALUOp, Funct3, Funct7, IsImm, OpA, OpB, ALUResult, res_ready,
        output in_ready, SrcA, SrcB, Operation, res_valid, Result, res_err
    );

    modport master (
        output in_valid, ALUOp, Funct3, Funct7, IsImm, OpA, OpB, ALUResult, res_ready,
        input  in_ready, SrcA, SrcB, Operation, res_valid, Result, res_err
    );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Maps ALUOp/Funct3/Funct7/IsImm to an ALU operation code and an illegal-decode flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the decode is sampled.
module alu_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_imm,
    output logic [3:0] op,
    output logic       err
);
    alu_op_e op_e;

    always_comb begin
        op_e = ALU_ILLEGAL;
        case (alu_op)
            ALUOP_MEM: op_e = ALU_ADD;
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000:  op_e = ALU_EQUAL;
                    3'b100:  op_e = ALU_SLT;
                    default: op_e = ALU_ILLEGAL;
                endcase
            end
            ALUOP_ARITH: begin
                case (funct3)
                    // Immediate forms have no SUB; funct7 bits there are part of the immediate.
                    3'b000:  op_e = (!is_imm && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b111:  op_e = ALU_AND;
                    3'b110:  op_e = ALU_OR;
                    3'b100:  op_e = ALU_XOR;
                    3'b001:  op_e = ALU_SLL;
                    3'b101:  op_e = (funct7 == 7'd0) ? ALU_SRL : ALU_ILLEGAL;
                    3'b010:  op_e = ALU_SLT;
                    default: op_e = ALU_ILLEGAL;
                endcase
            end
            default: op_e = ALU_LUI;
        endcase
    end

    assign op  = op_e;
    assign err = (op_e == ALU_ILLEGAL);
endmodule

// File: rtl/alu_issue_ctrl.sv
// Accepts one decoded ALU request, drives registered operands to the ALU, returns its result.
// Latency: result valid the cycle after the edge following accept; one result per 2 cycles max.
// Backpressure: holds the result and refuses new requests until res_ready; no request buffering.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus,
    output logic [15:0] op_count
);
    issue_state_e state;
    logic         err_q;
    logic [3:0]   dec_op;
    logic         dec_err;
    logic         accept;

    alu_decode u_decode (
        .alu_op (bus.ALUOp),
        .funct3 (bus.Funct3),
        .funct7 (bus.Funct7),
        .is_imm (bus.IsImm),
        .op     (dec_op),
        .err    (dec_err)
    );

    // in_ready follows res_ready combinationally in DONE so a result drain and a new accept share one edge.
    assign bus.in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.res_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.SrcA      <= '0;
            bus.SrcB      <= '0;
            bus.Operation <= '0;
            bus.Result    <= '0;
            bus.res_err   <= 1'b0;
            bus.res_valid <= 1'b0;
            err_q         <= 1'b0;
            op_count      <= 16'd0;
        end else begin
            if (accept) begin
                bus.SrcA      <= bus.OpA;
                bus.SrcB      <= bus.OpB;
                bus.Operation <= OPCODE_LENGTH'(dec_op);
                err_q         <= dec_err;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_EXEC;
                end
                ST_EXEC: begin
                    bus.Result    <= err_q ? {DATA_WIDTH{1'b0}} : bus.ALUResult;
                    bus.res_err   <= err_q;
                    bus.res_valid <= 1'b1;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        op_count      <= op_count + 16'd1;
                        state         <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the operand/result loop.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    typedef struct {
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        err;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] op_count;
    logic [15:0] exp_count = 16'd0;
    int          vectors     = 0;
    int          miscompares = 0;

    alu_issue_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

    alu_issue_ctrl #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; unknown codes return a non-zero marker so forced-zero results are visible.
    always_comb begin
        case (bus.Operation)
            ALU_AND:   bus.ALUResult = bus.SrcA & bus.SrcB;
            ALU_OR:    bus.ALUResult = bus.SrcA | bus.SrcB;
            ALU_ADD:   bus.ALUResult = bus.SrcA + bus.SrcB;
            ALU_SUB:   bus.ALUResult = bus.SrcA - bus.SrcB;
            ALU_XOR:   bus.ALUResult = bus.SrcA ^ bus.SrcB;
            ALU_SRL:   bus.ALUResult = bus.SrcA >> bus.SrcB[4:0];
            ALU_SLL:   bus.ALUResult = bus.SrcA << bus.SrcB[4:0];
            ALU_EQUAL: bus.ALUResult = {31'd0, bus.SrcA == bus.SrcB};
            ALU_LUI:   bus.ALUResult = bus.SrcB;
            ALU_SLT:   bus.ALUResult = {31'd0, $signed(bus.SrcA) < $signed(bus.SrcB)};
            default:   bus.ALUResult = 32'hDEAD_BEEF;
        endcase
    end

    task automatic issue(input logic [1:0] aluop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic imm, input logic [31:0] a, input logic [31:0] b);
        bus.ALUOp    = aluop;
        bus.Funct3   = f3;
        bus.Funct7   = f7;
        bus.IsImm    = imm;
        bus.OpA      = a;
        bus.OpB      = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.res_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        exp_count     = exp_count + 16'd1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        vectors++; if (bus.Result !== 32'd0) begin miscompares++; $display("FAIL rst_result: got %h want 0", bus.Result); end
        vectors++; if (bus.res_err !== 1'b0) begin miscompares++; $display("FAIL rst_res_err: got %b want 0", bus.res_err); end
        vectors++; if (bus.Operation !== 4'd0) begin miscompares++; $display("FAIL rst_operation: got %b want 0000", bus.Operation); end
        vectors++; if (bus.SrcA !== 32'd0 || bus.SrcB !== 32'd0) begin miscompares++; $display("FAIL rst_src: got %h/%h want 0/0", bus.SrcA, bus.SrcB); end
        vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL rst_op_count: got %h want 0", op_count); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_sub();
        int n;
        issue(2'b10, 3'b000, 7'h20, 1'b0, 32'd10, 32'd3);
        vectors++; if (bus.Operation !== 4'b0011) begin miscompares++; $display("FAIL sub_operation: got %b want 0011", bus.Operation); end
        vectors++; if (bus.SrcA !== 32'd10 || bus.SrcB !== 32'd3) begin miscompares++; $display("FAIL sub_src: got %0d/%0d want 10/3", bus.SrcA, bus.SrcB); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL sub_exec_in_ready: got %b want 0", bus.in_ready); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL sub_exec_res_valid: got %b want 0", bus.res_valid); end
        wait_valid(n);
        vectors++; if (n != 1) begin miscompares++; $display("FAIL sub_latency: got %0d want 1 extra cycle", n); end
        vectors++; if (bus.Result !== 32'd7) begin miscompares++; $display("FAIL sub_result: got %0d want 7", bus.Result); end
        vectors++; if (bus.res_err !== 1'b0) begin miscompares++; $display("FAIL sub_res_err: got %b want 0", bus.res_err); end
        handshake();
        vectors++; if (op_count !== exp_count) begin miscompares++; $display("FAIL sub_op_count: got %0d want %0d", op_count, exp_count); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL sub_drain: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_decode();
        int   n;
        vec_t tbl [15];
        tbl = '{
            '{2'b00, 3'b000, 7'h00, 1'b0, 32'd100,        32'd28,         4'b0010, 32'd128,        1'b0},
            '{2'b11, 3'b000, 7'h00, 1'b0, 32'd0,          32'h1234_5000,  4'b1001, 32'h1234_5000,  1'b0},
            '{2'b01, 3'b000, 7'h00, 1'b0, 32'd5,          32'd5,          4'b1000, 32'd1,          1'b0},
            '{2'b01, 3'b100, 7'h00, 1'b0, 32'hFFFF_FFFF,  32'd1,          4'b1110, 32'd1,          1'b0},
            '{2'b10, 3'b000, 7'h20, 1'b1, 32'd10,         32'd3,          4'b0010, 32'd13,         1'b0},
            '{2'b10, 3'b111, 7'h00, 1'b0, 32'h0000_F0F0,  32'h0000_FF00,  4'b0000, 32'h0000_F000,  1'b0},
            '{2'b10, 3'b110, 7'h00, 1'b0, 32'h0000_F0F0,  32'h0000_0F0F,  4'b0001, 32'h0000_FFFF,  1'b0},
            '{2'b10, 3'b100, 7'h00, 1'b0, 32'h0000_00FF,  32'h0000_000F,  4'b0100, 32'h0000_00F0,  1'b0},
            '{2'b10, 3'b001, 7'h00, 1'b0, 32'd1,          32'd4,          4'b0110, 32'd16,         1'b0},
            '{2'b10, 3'b101, 7'h00, 1'b0, 32'h0000_0080,  32'd3,          4'b0101, 32'h0000_0010,  1'b0},
            '{2'b10, 3'b101, 7'h20, 1'b0, 32'h0000_0080,  32'd3,          4'b1111, 32'd0,          1'b1},
            '{2'b10, 3'b010, 7'h00, 1'b0, 32'd3,          32'd7,          4'b1110, 32'd1,          1'b0},
            '{2'b10, 3'b011, 7'h00, 1'b0, 32'd1,          32'd2,          4'b1111, 32'd0,          1'b1},
            '{2'b01, 3'b011, 7'h00, 1'b0, 32'd4,          32'd4,          4'b1111, 32'd0,          1'b1},
            '{2'b10, 3'b000, 7'h00, 1'b0, 32'd9,          32'd4,          4'b0010, 32'd13,         1'b0}
        };
        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].aluop, tbl[i].f3, tbl[i].f7, tbl[i].imm, tbl[i].a, tbl[i].b);
            wait_valid(n);
            vectors++; if (n != 1) begin miscompares++; $display("FAIL dec%0d_latency: got %0d want 1", i, n); end
            vectors++; if (bus.Operation !== tbl[i].op) begin miscompares++; $display("FAIL dec%0d_operation: got %b want %b", i, bus.Operation, tbl[i].op); end
            vectors++; if (bus.Result !== tbl[i].res) begin miscompares++; $display("FAIL dec%0d_result: got %h want %h", i, bus.Result, tbl[i].res); end
            vectors++; if (bus.res_err !== tbl[i].err) begin miscompares++; $display("FAIL dec%0d_res_err: got %b want %b", i, bus.res_err, tbl[i].err); end
            handshake();
            vectors++; if (op_count !== exp_count) begin miscompares++; $display("FAIL dec%0d_op_count: got %0d want %0d", i, op_count, exp_count); end
        end
    endtask

    task automatic test_stall();
        int n;
        issue(2'b10, 3'b000, 7'h00, 1'b0, 32'd20, 32'd22);
        wait_valid(n);
        vectors++; if (n != 1) begin miscompares++; $display("FAIL stall_latency: got %0d want 1", n); end
        bus.ALUOp = 2'b00; bus.OpA = 32'd999; bus.OpB = 32'd1; bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL stall%0d_res_valid: got %b want 1", c, bus.res_valid); end
            vectors++; if (bus.Result !== 32'd42) begin miscompares++; $display("FAIL stall%0d_result: got %0d want 42", c, bus.Result); end
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall%0d_in_ready: got %b want 0", c, bus.in_ready); end
            vectors++; if (bus.SrcA !== 32'd20) begin miscompares++; $display("FAIL stall%0d_srca: got %0d want 20", c, bus.SrcA); end
        end
        bus.in_valid = 1'b0;
        handshake();
        vectors++; if (op_count !== exp_count) begin miscompares++; $display("FAIL stall_op_count: got %0d want %0d", op_count, exp_count); end
        @(negedge clk);
        vectors++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_idle: got valid=%b ready=%b want 0/1", bus.res_valid, bus.in_ready); end
        vectors++; if (op_count !== exp_count) begin miscompares++; $display("FAIL stall_single_inc: got %0d want %0d", op_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(2'b00, 3'b000, 7'h00, 1'b0, 32'd7, 32'd8);
        wait_valid(n);
        vectors++; if (bus.Result !== 32'd15) begin miscompares++; $display("FAIL b2b_first_result: got %0d want 15", bus.Result); end
        bus.ALUOp = 2'b10; bus.Funct3 = 3'b100; bus.Funct7 = 7'h00; bus.IsImm = 1'b0;
        bus.OpA = 32'h0000_00AA; bus.OpB = 32'h0000_0055;
        bus.in_valid = 1'b1; bus.res_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got %b want 0", bus.res_valid); end
        vectors++; if (bus.Operation !== 4'b0100 || bus.SrcA !== 32'h0000_00AA) begin miscompares++; $display("FAIL b2b_accept: got op=%b srca=%h want 0100/aa", bus.Operation, bus.SrcA); end
        vectors++; if (op_count !== exp_count) begin miscompares++; $display("FAIL b2b_op_count: got %0d want %0d", op_count, exp_count); end
        wait_valid(n);
        vectors++; if (n != 1) begin miscompares++; $display("FAIL b2b_latency: got %0d want 1", n); end
        vectors++; if (bus.Result !== 32'h0000_00FF) begin miscompares++; $display("FAIL b2b_second_result: got %h want ff", bus.Result); end
        handshake();
    endtask

    task automatic test_wrap();
        int n;
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        exp_count = 16'hFFFF;
        issue(2'b00, 3'b000, 7'h00, 1'b0, 32'd1, 32'd1);
        wait_valid(n);
        handshake();
        vectors++; if (op_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_zero: got %h want 0000", op_count); end
        issue(2'b00, 3'b000, 7'h00, 1'b0, 32'd2, 32'd2);
        wait_valid(n);
        handshake();
        vectors++; if (op_count !== 16'h0001) begin miscompares++; $display("FAIL wrap_one: got %h want 0001", op_count); end
    endtask

    task automatic test_reset_exec();
        issue(2'b00, 3'b000, 7'h00, 1'b0, 32'd5, 32'd6);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.res_valid !== 1'b0 || bus.Result !== 32'd0) begin miscompares++; $display("FAIL rexec_result: got valid=%b res=%h want 0/0", bus.res_valid, bus.Result); end
        vectors++; if (bus.SrcA !== 32'd0 || bus.Operation !== 4'd0) begin miscompares++; $display("FAIL rexec_src: got srca=%h op=%b want 0/0000", bus.SrcA, bus.Operation); end
        vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL rexec_op_count: got %h want 0", op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL rexec%0d_res_valid: got %b want 0", c, bus.res_valid); end
            vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL rexec%0d_op_count: got %h want 0", c, op_count); end
        end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rexec_in_ready: got %b want 1", bus.in_ready); end
        bus.res_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        bus.ALUOp     = 2'b00;
        bus.Funct3    = 3'b000;
        bus.Funct7    = 7'h00;
        bus.IsImm     = 1'b0;
        bus.OpA       = 32'd0;
        bus.OpB       = 32'd0;
        test_reset();
        test_sub();
        test_decode();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
